// File: rtl/skid_pkg.sv
// ============================================================================
// Module      : skid_pkg
// Description : Shared state encoding and widths for the skid_stage block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } state_t;

    localparam int STALL_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/ConfigurableRegister.sv
// ============================================================================
// Module      : ConfigurableRegister
// Description : WIDTH-bit storage register with synchronous reset and load enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ConfigurableRegister #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else if (i_load) begin
            o_q <= i_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/skid_stage.sv
// ============================================================================
// Module      : skid_stage
// Description : Two-entry valid/ready skid buffer with registered s_ready.
//               Define SKID_STAGE_STATS_EN to add the saturating stall_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_stage
    import skid_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data
`ifdef SKID_STAGE_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_up_xfer;
    logic               w_dn_xfer;
    logic               w_load_main;
    logic               w_load_skid;
    logic [WIDTH-1:0]   w_main_d;
    logic [WIDTH-1:0]   w_main_q;
    logic [WIDTH-1:0]   w_skid_q;

    // Handshake outputs decode only the state register, never m_ready.
    assign s_ready   = (r_state != SKID);
    assign m_valid   = (r_state != EMPTY);
    assign m_data    = w_main_q;
    assign w_up_xfer = s_valid && s_ready;
    assign w_dn_xfer = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_main_d    = s_data;
        case (r_state)
            EMPTY: begin
                if (w_up_xfer) begin
                    w_load_main = 1'b1;
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (w_up_xfer && w_dn_xfer) begin
                    w_load_main = 1'b1;
                end else if (w_up_xfer) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = SKID;
                end else if (w_dn_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            SKID: begin
                w_main_d = w_skid_q;
                if (w_dn_xfer) begin
                    w_load_main = 1'b1;
                    w_state_nxt = FULL;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
        // Flush drops everything in flight but leaves stored payloads untouched.
        if (flush) begin
            w_state_nxt = EMPTY;
            w_load_main = 1'b0;
            w_load_skid = 1'b0;
        end
    end

    ConfigurableRegister #(.WIDTH(WIDTH)) u_main_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_main),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    ConfigurableRegister #(.WIDTH(WIDTH)) u_skid_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_skid),
        .i_d    (s_data),
        .o_q    (w_skid_q)
    );

`ifdef SKID_STAGE_STATS_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (m_valid && !m_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_skid_stage.sv
// ============================================================================
// Module      : tb_skid_stage
// Description : Self-checking bench for skid_stage: directed vector table plus
//               randomized traffic against a queue model (SKID_STAGE_STATS_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_skid_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
`ifdef SKID_STAGE_STATS_EN
    logic [15:0]      stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    skid_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
`ifdef SKID_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        logic        emv;
        logic [31:0] emd;
        logic        esr;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    initial begin
        logic [31:0] q[$];
        logic [31:0] payload;
        logic [31:0] exp_out;
        logic [31:0] prev_md;
        logic        prev_stall;
        logic        mv_m;
        logic        sr_m;
        int          exp_stall;

        //          rst   flush sv    sd      mr    emv   emd     esr
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h99, 1'b1, 1'b0, 32'h00, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 32'h11, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 32'h22, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 32'h33, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h33, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 32'hA1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 32'hA1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'hFF, 1'b0, 1'b1, 32'hA1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'hA2, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'hA2, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'hB1, 1'b0, 1'b1, 32'hB1, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hB2, 1'b0, 1'b1, 32'hB1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'hB3, 1'b0, 1'b0, 32'hB1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'hB1, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h5A, 1'b0, 1'b1, 32'h5A, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 32'h77, 1'b1, 1'b0, 32'h00, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 32'hC1, 1'b0, 1'b1, 32'hC1, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 32'hC2, 1'b1, 1'b0, 32'hC1, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'hC1, 1'b1};

        for (int i = 0; i < NVEC; i++) begin
            rst     = vecs[i].rst;
            flush   = vecs[i].flush;
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            m_ready = vecs[i].mr;
            tick();
            check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].emv));
            check($sformatf("vec%0d_m_data", i),  m_data,        vecs[i].emd);
            check($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].esr));
        end

        // Randomized traffic against a FIFO-of-at-most-two model.
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        tick();
        rst = 1'b0;
        payload    = 32'd1;
        exp_out    = 32'd1;
        prev_stall = 1'b0;
        prev_md    = '0;
        exp_stall  = 0;
        for (int i = 0; i < 10000; i++) begin
            mv_m = (q.size() != 0);
            sr_m = (q.size() < 2);
            check("rnd_m_valid", 32'(m_valid), 32'(mv_m));
            check("rnd_s_ready", 32'(s_ready), 32'(sr_m));
            if (mv_m) check("rnd_head", m_data, q[0]);
            if (prev_stall) check("rnd_stable", m_data, prev_md);
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = payload;
            if (mv_m && m_ready) begin
                check("rnd_order", m_data, exp_out);
                exp_out++;
                void'(q.pop_front());
            end
            if (s_valid && sr_m) begin
                q.push_back(payload);
                payload++;
            end
            if (mv_m && !m_ready && exp_stall < 65535) exp_stall++;
            prev_stall = mv_m && !m_ready;
            prev_md    = m_data;
            tick();
        end
`ifdef SKID_STAGE_STATS_EN
        check("rnd_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // Saturation: one beat held with the sink stalled.
        s_valid = 1'b0; m_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stat_reset", 32'(stall_cnt), 32'h0);
        s_valid = 1'b1; s_data = 32'hE1;
        tick();
        s_valid = 1'b0;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (i == 1000) check("stat_1000", 32'(stall_cnt), 32'd1000);
        end
        check("stat_sat", 32'(stall_cnt), 32'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("stat_sat_hold", 32'(stall_cnt), 32'hFFFF);
        check("stat_m_valid", 32'(m_valid), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
